// File: rtl/vscale_xvec_lane_sequencer_pkg.sv
// Shared constants for the xvec lane sequencer: src-B selects, default geometry, FSM encodings.
// The FSM encodings are plain constants so legacy code comparing raw state values keeps working.
package vscale_xvec_lane_sequencer_pkg;

    localparam int SRC_B_SEL_WIDTH = 2;
    localparam logic [SRC_B_SEL_WIDTH-1:0] SRC_B_RS2  = 2'd0;
    localparam logic [SRC_B_SEL_WIDTH-1:0] SRC_B_IMM  = 2'd1;
    localparam logic [SRC_B_SEL_WIDTH-1:0] SRC_B_FOUR = 2'd2;
    localparam logic [SRC_B_SEL_WIDTH-1:0] SRC_B_ZERO = 2'd3;

    localparam int XVEC_VEC_LEN = 8;
    localparam int XVEC_LANES   = 2;

    localparam int XVEC_SEQ_STATE_WIDTH = 2;
    localparam logic [XVEC_SEQ_STATE_WIDTH-1:0] XVEC_SEQ_IDLE = 2'd0;
    localparam logic [XVEC_SEQ_STATE_WIDTH-1:0] XVEC_SEQ_RUN  = 2'd1;
    localparam logic [XVEC_SEQ_STATE_WIDTH-1:0] XVEC_SEQ_DONE = 2'd2;

    // Beat counter needs at least one bit even when a vector fits in a single beat.
    function automatic int xvec_beat_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/vscale_xvec_src_b_bcast.sv
// Resolves the source-B select into a full-width operand vector (rs2, broadcast imm, four, zero).
module vscale_xvec_src_b_bcast
    import vscale_xvec_lane_sequencer_pkg::*;
#(
    parameter int XPR_LEN = 32,
    parameter int VEC_LEN = XVEC_VEC_LEN
) (
    input  logic [SRC_B_SEL_WIDTH-1:0]   src_b_sel,
    input  logic [XPR_LEN-1:0]           imm,
    input  logic [VEC_LEN*XPR_LEN-1:0]   rs2_data,
    output logic [VEC_LEN*XPR_LEN-1:0]   src_b
);

    localparam int VW = VEC_LEN * XPR_LEN;

    logic [VW-1:0] imm_vec;
    logic [VW-1:0] four_vec;

    genvar i;
    generate
        for (i = 0; i < VEC_LEN; i++) begin : g_imm_rep
            assign imm_vec[i*XPR_LEN +: XPR_LEN] = imm;
        end
    endgenerate

    // Only element 0 carries the constant; the remaining elements are zero.
    assign four_vec = VW'(3'd4);

    always_comb begin
        src_b = '0;
        case (src_b_sel)
            SRC_B_RS2:  src_b = rs2_data;
            SRC_B_IMM:  src_b = imm_vec;
            SRC_B_FOUR: src_b = four_vec;
            default:    src_b = '0;
        endcase
    end

endmodule

// File: rtl/vscale_xvec_lane_sequencer.sv
// Strip-mines one xvec ALU operation over a LANES-wide shared ALU, one beat per cycle,
// and returns the assembled result vector over a valid/ready handshake.
module vscale_xvec_lane_sequencer
    import vscale_xvec_lane_sequencer_pkg::*;
#(
    parameter int XPR_LEN = 32,
    parameter int VEC_LEN = XVEC_VEC_LEN,
    parameter int LANES   = XVEC_LANES
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         kill,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [3:0]                   req_alu_op,
    input  logic [SRC_B_SEL_WIDTH-1:0]   req_src_b_sel,
    input  logic [XPR_LEN-1:0]           req_imm,
    input  logic [VEC_LEN*XPR_LEN-1:0]   req_rs1_data,
    input  logic [VEC_LEN*XPR_LEN-1:0]   req_rs2_data,
    input  logic                         stall,
    output logic                         alu_valid,
    output logic [3:0]                   alu_op,
    output logic [LANES*XPR_LEN-1:0]     alu_src_a,
    output logic [LANES*XPR_LEN-1:0]     alu_src_b,
    input  logic [LANES*XPR_LEN-1:0]     alu_result,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [VEC_LEN*XPR_LEN-1:0]   resp_data
);

    localparam int BEATS  = VEC_LEN / LANES;
    localparam int BEAT_W = xvec_beat_width(BEATS);
    localparam int VW     = VEC_LEN * XPR_LEN;
    localparam int SW     = LANES * XPR_LEN;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    logic [XVEC_SEQ_STATE_WIDTH-1:0] state;
    logic [BEAT_W-1:0]               beat;
    logic [VW-1:0]                   a_buf;
    logic [VW-1:0]                   b_buf;
    logic [VW-1:0]                   r_buf;
    logic [3:0]                      op_q;
    logic [VW-1:0]                   src_b_full;

    vscale_xvec_src_b_bcast #(
        .XPR_LEN (XPR_LEN),
        .VEC_LEN (VEC_LEN)
    ) u_src_b_bcast (
        .src_b_sel (req_src_b_sel),
        .imm       (req_imm),
        .rs2_data  (req_rs2_data),
        .src_b     (src_b_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= XVEC_SEQ_IDLE;
            beat  <= '0;
            a_buf <= '0;
            b_buf <= '0;
            r_buf <= '0;
            op_q  <= '0;
        end else if (kill) begin
            state <= XVEC_SEQ_IDLE;
            beat  <= '0;
        end else begin
            case (state)
                XVEC_SEQ_IDLE: begin
                    if (req_valid) begin
                        a_buf <= req_rs1_data;
                        b_buf <= src_b_full;
                        op_q  <= req_alu_op;
                        beat  <= '0;
                        state <= XVEC_SEQ_RUN;
                    end
                end
                XVEC_SEQ_RUN: begin
                    if (!stall) begin
                        for (int unsigned b = 0; b < BEATS; b++) begin
                            if (beat == BEAT_W'(b)) r_buf[b*SW +: SW] <= alu_result;
                        end
                        if (beat == LAST_BEAT) begin
                            beat  <= '0;
                            state <= XVEC_SEQ_DONE;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                XVEC_SEQ_DONE: begin
                    if (resp_ready) state <= XVEC_SEQ_IDLE;
                end
                default: state <= XVEC_SEQ_IDLE;
            endcase
        end
    end

    // Operand slices are forced to zero outside RUN so stale buffers never reach the ALU.
    always_comb begin
        alu_src_a = '0;
        alu_src_b = '0;
        if (state == XVEC_SEQ_RUN) begin
            for (int unsigned b = 0; b < BEATS; b++) begin
                if (beat == BEAT_W'(b)) begin
                    alu_src_a = a_buf[b*SW +: SW];
                    alu_src_b = b_buf[b*SW +: SW];
                end
            end
        end
    end

    assign req_ready  = (state == XVEC_SEQ_IDLE) && !kill;
    assign alu_valid  = (state == XVEC_SEQ_RUN);
    assign alu_op     = op_q;
    assign resp_valid = (state == XVEC_SEQ_DONE);
    assign resp_data  = (state == XVEC_SEQ_DONE) ? r_buf : '0;

endmodule

// File: doc/vscale_xvec_lane_sequencer.md
Name: vscale_xvec_lane_sequencer

Overview:
Strip-mines one xvec ALU operation of VEC_LEN elements over a shared ALU datapath of LANES elements per beat. Accepts a request from xvec decode/issue and resolves the source-B operand (rs2, broadcast immediate, constant four, zero). Drives the shared ALU for VEC_LEN/LANES beats, assembles the full result vector and returns it over a valid/ready handshake. Sits between the xvec issue stage and the lane ALU, replacing full-width src-B muxing with per-beat sequencing.

Parameters:
XPR_LEN, 32, element width in bits
VEC_LEN, 8, elements per vector; must be a multiple of LANES
LANES, 2, elements processed per ALU beat
BEATS, VEC_LEN/LANES, derived (localparam); beat counter width clog2(BEATS), minimum 1

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
kill  in  1  pipeline flush; aborts any operation
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready
req_alu_op  in  4  ALU opcode, passed to ALU unchanged
req_src_b_sel  in  SRC_B_SEL_WIDTH  SRC_B_RS2 / SRC_B_IMM / SRC_B_FOUR / other
req_imm  in  XPR_LEN  immediate
req_rs1_data  in  VEC_LEN*XPR_LEN  source-A vector, element i at bits [i*XPR_LEN +: XPR_LEN]
req_rs2_data  in  VEC_LEN*XPR_LEN  source-B vector
stall  in  1  holds current beat
alu_valid  out  1  beat operands valid
alu_op  out  4  latched opcode
alu_src_a  out  LANES*XPR_LEN  source-A elements of current beat
alu_src_b  out  LANES*XPR_LEN  source-B elements of current beat
alu_result  in  LANES*XPR_LEN  combinational ALU result for current beat, same cycle
resp_valid  out  1  result vector complete
resp_ready  in  1  consumer accepts
resp_data  out  VEC_LEN*XPR_LEN  assembled result vector

Behaviour:
- Reset (reset low, asynchronous): state IDLE, beat counter 0, operand/result buffers 0, alu_op 0. alu_valid=0, resp_valid=0, resp_data=0, alu_src_a/b=0, req_ready=1.
- States: IDLE, RUN, DONE; encodings in shared header.
- IDLE: req_ready = !kill. On accept, latch rs1 vector, opcode, and the resolved src-B vector; go to RUN, beat=0.
- src-B resolution at capture: RS2 -> rs2 vector; IMM -> req_imm replicated into all VEC_LEN elements; FOUR -> element 0 = 4, all other elements 0; other -> all zero.
- RUN: alu_valid=1. alu_src_a/b = latched elements [beat*LANES .. beat*LANES+LANES-1]. If !stall: write alu_result into the result buffer at the same element positions and increment beat. On the last beat (beat==BEATS-1) go to DONE. If stall: beat, outputs and buffer are held; the result is not written.
- DONE: alu_valid=0, resp_valid=1, resp_data = result buffer. On resp_ready go to IDLE. resp_valid and resp_data stay stable while resp_ready is low.
- Latency with no stall: request accepted in cycle 0, beats in cycles 1..BEATS, resp_valid first high in cycle BEATS+1. Each stall cycle adds one cycle.
- No new request is accepted in RUN or DONE. req_ready is 0 there.
- kill (highest priority, any state): next state IDLE, beat 0. alu_valid and resp_valid are low from the next cycle. No response is produced. The result buffer is not cleared but is never exposed. kill in IDLE together with req_valid: the request is not accepted.
- kill together with resp_ready in DONE: go to IDLE. The handshake counts as completed.
- BEATS==1: RUN lasts one cycle (unless stalled), then DONE.
- Reset asserted mid-RUN or mid-DONE: all outputs take reset values immediately. In-flight data is discarded.

Decomposition:
- Shared header xvec/xvec_defines.vh: XVEC_VEC_LEN, XVEC_LANES, XVEC_SEQ_STATE_WIDTH, XVEC_SEQ_IDLE/RUN/DONE encodings. SRC_B_* selects come from vscale_ctrl_constants.vh.
- One sub-module: vscale_xvec_src_b_bcast. It is combinational, parameterised by VEC_LEN, and resolves src_b_sel/imm/rs2 into the full-width B vector using a generate loop for replication.
- The sequencer FSM, beat counter, slicing and result buffer live in the top module.

Test Plan:
- VEC_LEN=8, LANES=2; rs1 element i = i, rs2 element i = 10*i, SRC_B_RS2, bench ALU = add -> 4 beats in cycles 1..4; resp_valid in cycle 5; resp_data element i = 11*i.
- SRC_B_IMM, imm=0x7 -> every beat alu_src_b = {0x7,0x7}; with rs1 all 1 and add, every result element = 0x8.
- SRC_B_FOUR -> beat 0 alu_src_b = {0,4} (lane0=4); beats 1..3 alu_src_b = 0; result element 0 = rs1[0]+4, others equal rs1.
- stall held high 3 cycles during beat 2 -> alu_src_a/b unchanged for those cycles; resp_valid in cycle 8; data identical to the unstalled run.
- kill in beat 1 -> next cycle alu_valid=0, req_ready=1, no resp_valid ever. A following RS2 request then completes correctly.
- resp_ready low 5 cycles in DONE -> resp_valid/resp_data stable. Separately, reset pulled low mid-RUN -> alu_valid=0 and resp_data=0 asynchronously; after release req_ready=1.
